// File: rtl/fu_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined functional unit among
// several cores; a tag pipeline tracks each issued op and steers its result home.
module fu_share_arbiter #(
    parameter int W       = 64,
    parameter int NCORE   = 4,
    parameter int LAT     = 7,
    parameter int OPW     = 3,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORE-1:0]     req,
    input  logic [NCORE*W-1:0]   op_a,
    input  logic [NCORE*W-1:0]   op_b,
    input  logic [NCORE*OPW-1:0] op_code,
    output logic [NCORE-1:0]     gnt,
    output logic                 fu_valid,
    output logic [W-1:0]         fu_a,
    output logic [W-1:0]         fu_b,
    output logic [OPW-1:0]       fu_op,
    input  logic [W-1:0]         fu_result,
    output logic [NCORE-1:0]     res_valid,
    output logic [W-1:0]         res_data,
    output logic                 busy
);

    localparam int IW  = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int IW1 = IW + 1;
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    logic [IW-1:0]             ptr_reg, ptr_next;
    logic [NCORE-1:0][CW-1:0]  cnt_reg, cnt_next;
    logic [LAT-1:0]            tag_valid_reg;
    logic [LAT-1:0][IW-1:0]    tag_id_reg;
    logic [NCORE-1:0]          elig;
    logic                      found;
    logic [IW-1:0]             gnt_id;
    logic [IW:0]               arb_sum;
    logic [IW-1:0]             arb_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NCORE; gi++) begin : g_core
            // Eligibility uses only the registered count; a return this cycle frees a slot next cycle.
            assign elig[gi]      = req[gi] && (cnt_reg[gi] < CNT_MAX);
            assign gnt[gi]       = found && (gnt_id == IW'(gi));
            assign res_valid[gi] = tag_valid_reg[LAT-1] && (tag_id_reg[LAT-1] == IW'(gi));
            assign cnt_next[gi]  = (gnt[gi] && !res_valid[gi]) ? cnt_reg[gi] + CW'(1) :
                                   (!gnt[gi] && res_valid[gi]) ? cnt_reg[gi] - CW'(1) :
                                   cnt_reg[gi];
        end
    endgenerate

    always_comb begin
        found   = 1'b0;
        gnt_id  = '0;
        arb_sum = '0;
        arb_idx = '0;
        for (int k = 0; k < NCORE; k++) begin
            arb_sum = {1'b0, ptr_reg} + IW1'(k);
            if (arb_sum >= IW1'(NCORE)) begin
                arb_sum = arb_sum - IW1'(NCORE);
            end
            arb_idx = arb_sum[IW-1:0];
            if (!found && elig[arb_idx]) begin
                found  = 1'b1;
                gnt_id = arb_idx;
            end
        end
        if (rst) begin
            found = 1'b0;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (found) begin
            ptr_next = (gnt_id == IW'(NCORE - 1)) ? '0 : gnt_id + IW'(1);
        end
    end

    // One-hot grant makes an AND-OR mux; idle cycles present zeros to the unit.
    always_comb begin
        fu_a  = '0;
        fu_b  = '0;
        fu_op = '0;
        for (int i = 0; i < NCORE; i++) begin
            if (gnt[i]) begin
                fu_a  = fu_a  | op_a[i*W +: W];
                fu_b  = fu_b  | op_b[i*W +: W];
                fu_op = fu_op | op_code[i*OPW +: OPW];
            end
        end
    end

    assign fu_valid = found;
    assign res_data = fu_result;
    assign busy     = |tag_valid_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            cnt_reg       <= '0;
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            ptr_reg          <= ptr_next;
            cnt_reg          <= cnt_next;
            tag_valid_reg[0] <= found;
            tag_id_reg[0]    <= gnt_id;
            for (int k = 1; k < LAT; k++) begin
                tag_valid_reg[k] <= tag_valid_reg[k-1];
                tag_id_reg[k]    <= tag_id_reg[k-1];
            end
        end
    end

endmodule

// File: tb/tb_fu_share_arbiter.sv
// Directed bench for fu_share_arbiter with a behavioural 7-stage functional unit
// (op 0=AND, 1=OR, 2=XOR, 3=ADD, other=SUB).
module tb_fu_share_arbiter;

    localparam int W = 64, NCORE = 4, LAT = 7, OPW = 3, MAX_OUT = 4;

    logic                 clk, rst;
    logic [NCORE-1:0]     req;
    logic [NCORE*W-1:0]   op_a, op_b;
    logic [NCORE*OPW-1:0] op_code;
    logic [NCORE-1:0]     gnt, res_valid;
    logic                 fu_valid, busy;
    logic [W-1:0]         fu_a, fu_b, fu_result, res_data;
    logic [OPW-1:0]       fu_op;

    int n_assert = 0;
    int n_fail   = 0;

    fu_share_arbiter #(.W(W), .NCORE(NCORE), .LAT(LAT), .OPW(OPW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .op_code(op_code),
        .gnt(gnt), .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op),
        .fu_result(fu_result), .res_valid(res_valid), .res_data(res_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] fu_model(logic [W-1:0] a, logic [W-1:0] b, logic [OPW-1:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a + b;
            default: return a - b;
        endcase
    endfunction

    logic [W-1:0] fu_pipe [LAT];
    always @(posedge clk) begin
        fu_pipe[0] <= fu_valid ? fu_model(fu_a, fu_b, fu_op) : '0;
        for (int k = 1; k < LAT; k++) fu_pipe[k] <= fu_pipe[k-1];
    end
    assign fu_result = fu_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
        op_a[i*W +: W]        = a;
        op_b[i*W +: W]        = b;
        op_code[i*OPW +: OPW] = op;
    endtask

    logic [W-1:0] fair_a   [4] = '{64'h1000, 64'h2000, 64'h3000, 64'h4000};
    logic [W-1:0] fair_b   [4] = '{64'h1, 64'h2, 64'h3, 64'h4};
    logic [W-1:0] fair_res [4] = '{64'h1001, 64'h2002, 64'h3003, 64'h4004};
    int lim_gnt [13] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    int lim_cnt [13] = '{0, 1, 2, 3, 4, 4, 4, 4, 3, 3, 3, 3, 4};
    int lim_rv  [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        rst = 1'b1; req = '0; op_a = '0; op_b = '0; op_code = '0;

        // Reset: requests pending but nothing granted
        @(posedge clk); #1 req = '1;
        #2;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_fu_valid", 64'(fu_valid), 64'h0);
        chk("rst_res_valid", 64'(res_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        @(posedge clk); #1 rst = 1'b0; req = '0;

        // Single op on core2
        set_core(2, 64'h444F, 64'hFFFE, 3'd0);
        req = 4'b0100;
        #2;
        chk("t1_gnt", 64'(gnt), 64'h4);
        chk("t1_fu_valid", 64'(fu_valid), 64'h1);
        chk("t1_fu_a", fu_a, 64'h444F);
        chk("t1_fu_b", fu_b, 64'hFFFE);
        chk("t1_fu_op", 64'(fu_op), 64'h0);
        tick();
        req = '0;
        set_core(2, 64'hDEAD, 64'hBEEF, 3'd7);
        for (int c = 1; c <= 8; c++) begin
            #2;
            chk($sformatf("t1_busy_c%0d", c), 64'(busy), (c <= 7) ? 64'h1 : 64'h0);
            chk($sformatf("t1_res_valid_c%0d", c), 64'(res_valid), (c == 7) ? 64'h4 : 64'h0);
            if (c == 7) chk("t1_res_data", res_data, 64'h444E);
            tick();
        end

        // Reset pulse returns pointer to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Fairness: all four held for 14 cycles
        for (int i = 0; i < 4; i++) set_core(i, fair_a[i], fair_b[i], 3'd3);
        for (int c = 0; c <= 21; c++) begin
            req = (c < 14) ? 4'hF : 4'h0;
            #2;
            chk($sformatf("fair_gnt_c%0d", c), 64'(gnt), (c < 14) ? (64'h1 << (c % 4)) : 64'h0);
            if (c >= 7 && c <= 20) begin
                chk($sformatf("fair_rv_c%0d", c), 64'(res_valid), 64'h1 << ((c - 7) % 4));
                chk($sformatf("fair_data_c%0d", c), res_data, fair_res[(c - 7) % 4]);
            end else begin
                chk($sformatf("fair_rv_c%0d", c), 64'(res_valid), 64'h0);
            end
            tick();
        end
        #2 chk("fair_busy_end", 64'(busy), 64'h0);
        tick();

        // Outstanding limit on core0
        set_core(0, 64'h10, 64'h01, 3'd1);
        for (int c = 0; c <= 19; c++) begin
            req = (c <= 12) ? 4'h1 : 4'h0;
            #2;
            n_assert++;
            assert (dut.cnt_reg[0] <= 3'(MAX_OUT)) else begin
                n_fail++;
                $error("FAIL lim_cnt_range_c%0d: observed %0d expected <= %0d", c, dut.cnt_reg[0], MAX_OUT);
            end
            if (c <= 12) begin
                chk($sformatf("lim_gnt_c%0d", c), 64'(gnt), 64'(lim_gnt[c]));
                chk($sformatf("lim_cnt_c%0d", c), 64'(dut.cnt_reg[0]), 64'(lim_cnt[c]));
                chk($sformatf("lim_rv_c%0d", c), 64'(res_valid), 64'(lim_rv[c]));
                if (lim_rv[c] != 0) chk($sformatf("lim_data_c%0d", c), res_data, 64'h11);
            end
            if (c == 19) begin
                chk("lim_busy_end", 64'(busy), 64'h0);
                chk("lim_cnt_end", 64'(dut.cnt_reg[0]), 64'h0);
            end
            tick();
        end

        // Simultaneous grant and return on core1
        set_core(1, 64'hF0F0, 64'h0FF0, 3'd2);
        for (int c = 0; c <= 15; c++) begin
            req = (c == 0 || c == 7) ? 4'h2 : 4'h0;
            if (c == 7) set_core(1, 64'hAAAA, 64'h5555, 3'd2);
            #2;
            chk($sformatf("sim_gnt_c%0d", c), 64'(gnt), (c == 0 || c == 7) ? 64'h2 : 64'h0);
            chk($sformatf("sim_rv_c%0d", c), 64'(res_valid), (c == 7 || c == 14) ? 64'h2 : 64'h0);
            chk($sformatf("sim_cnt_c%0d", c), 64'(dut.cnt_reg[1]), (c >= 1 && c <= 14) ? 64'h1 : 64'h0);
            if (c == 7)  chk("sim_data_c7", res_data, 64'hFF00);
            if (c == 14) chk("sim_data_c14", res_data, 64'hFFFF);
            if (c == 15) chk("sim_busy_end", 64'(busy), 64'h0);
            tick();
        end

        // Pointer skip: move ptr to 1, then cores 3 and 0 compete
        set_core(0, 64'h123, 64'h1, 3'd3);
        set_core(3, 64'h3333, 64'h3, 3'd5);
        req = 4'b0001;
        #2 chk("skip_pre_gnt", 64'(gnt), 64'h1);
        tick();
        req = 4'b1001;
        #2;
        chk("skip_gnt3", 64'(gnt), 64'h8);
        chk("skip_fu_op3", 64'(fu_op), 64'h5);
        chk("skip_fu_a3", fu_a, 64'h3333);
        tick();
        #2;
        chk("skip_gnt0", 64'(gnt), 64'h1);
        chk("skip_fu_op0", 64'(fu_op), 64'h3);
        chk("skip_fu_a0", fu_a, 64'h123);
        tick();
        req = '0;
        repeat (8) tick();
        #2 chk("skip_busy_end", 64'(busy), 64'h0);
        tick();

        // Reset mid-flight
        for (int c = 0; c < 3; c++) begin
            req = 4'(1 << c);
            #2 chk($sformatf("rmf_gnt_c%0d", c), 64'(gnt), 64'h1 << c);
            tick();
        end
        rst = 1'b1;
        req = '1;
        #2;
        chk("rmf_rst_gnt", 64'(gnt), 64'h0);
        chk("rmf_rst_busy", 64'(busy), 64'h0);
        tick();
        rst = 1'b0;
        req = '0;
        for (int c = 4; c <= 9; c++) begin
            #2;
            chk($sformatf("rmf_rv_c%0d", c), 64'(res_valid), 64'h0);
            chk($sformatf("rmf_busy_c%0d", c), 64'(busy), 64'h0);
            if (c == 4) begin
                for (int i = 0; i < 3; i++)
                    chk($sformatf("rmf_cnt%0d", i), 64'(dut.cnt_reg[i]), 64'h0);
            end
            tick();
        end
        req = '1;
        #2 chk("rmf_first_gnt", 64'(gnt), 64'h1);
        tick();
        req = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
